// File: rtl/ls165_pkg.sv
// Shared width and register type for the 74LS165 shift-register model.
package ls165_pkg;
    localparam int unsigned LS165_W = 8;

    typedef logic [LS165_W-1:0] sr_t;
endpackage

// File: rtl/ttl_edge_det.sv
// Rising-edge detector for a TTL logic net sampled in the clk_sys domain.
// The delayed sample resets high so a net already high after reset never reads as an edge.
module ttl_edge_det (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic d_q;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) d_q <= 1'b1;
        else        d_q <= d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/ls165.sv
// 74LS165 parallel-in/serial-out shift register, emulated synchronously on clk_sys.
// The TTL clk/clk_inh pins are plain logic nets; shifting happens on a sampled rise of clk | clk_inh.
module ls165
    import ls165_pkg::*;
#(
    parameter sr_t INIT = 8'h00
) (
    input  logic               clk_sys,
    input  logic               rst_n,
    input  logic               sh_ld_n,
    input  logic               clk,
    input  logic               clk_inh,
    input  logic               ser,
    input  logic [LS165_W-1:0] p,
    output logic               qh,
    output logic               qh_n
);
    sr_t  q;
    logic eck_c;
    logic shift_c;

    // Inhibit is ORed into the clock, as on the real part.
    assign eck_c = clk | clk_inh;

    ttl_edge_det u_edge (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .d       (eck_c),
        .rise    (shift_c)
    );

    // Reset beats load, load beats a coincident shift edge.
    always_ff @(posedge clk_sys) begin
        if (!rst_n)        q <= INIT;
        else if (!sh_ld_n) q <= p;
        else if (shift_c)  q <= {q[LS165_W-2:0], ser};
    end

    assign qh   = q[LS165_W-1];
    assign qh_n = ~q[LS165_W-1];
endmodule
